// File: rtl/icache_refill_wb.sv
// Instruction-cache line-refill master: one line-fill command -> one Wishbone B4
// incrementing burst read -> LINE_WORDS in-order response beats to the cache.
// Optional per-beat watchdog with abort path: define ICACHE_REFILL_TIMEOUT_EN.
module icache_refill_wb #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LINE_WORDS     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                          clk,
    input  logic                                          reset,
    // line-fill command from the cache line loader
    input  logic                                          cmd_valid,
    output logic                                          cmd_ready,
    input  logic [ADDR_WIDTH-1:0]                         cmd_address,
    // response beats to the cache (no backpressure)
    output logic                                          rsp_valid,
    output logic [DATA_WIDTH-1:0]                         rsp_data,
    output logic                                          rsp_error,
    output logic                                          rsp_last,
    // Wishbone B4 master
    output logic                                          wb_cyc,
    output logic                                          wb_stb,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]    wb_adr,
    output logic [DATA_WIDTH/8-1:0]                       wb_sel,
    output logic [2:0]                                    wb_cti,
    output logic [1:0]                                    wb_bte,
    input  logic [DATA_WIDTH-1:0]                         wb_dat_r,
    input  logic                                          wb_ack,
    input  logic                                          wb_err
);

    localparam int unsigned ByteOffBits = $clog2(DATA_WIDTH / 8);
    localparam int unsigned LineOffBits = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int unsigned WbAdrW      = ADDR_WIDTH - ByteOffBits;
    localparam int unsigned CntW        = $clog2(LINE_WORDS);

    localparam logic [CntW-1:0]       LastBeat = CntW'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LineMask = {ADDR_WIDTH{1'b1}} << LineOffBits;
    localparam logic [2:0]            CtiIncr  = 3'b010;
    localparam logic [2:0]            CtiEnd   = 3'b111;

    // Reject configurations the datapath cannot represent.
    if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 ||
        LINE_WORDS < 2 || LINE_WORDS > 64 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("icache_refill_wb: illegal parameter combination");
    end

`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBurst, StAbort} state_e;

    logic [TimeoutW-1:0] wd_q;
`else
    typedef enum logic {StIdle, StBurst} state_e;
`endif

    state_e          state_q;
    logic [CntW-1:0] beat_cnt;

    assign wb_sel = '1;
    assign wb_bte = 2'b00;

    // Ready is a pure decode of the state, forced low while reset is held.
    assign cmd_ready = (state_q == StIdle) && !reset;

    // Refill FSM with registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            beat_cnt  <= '0;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_adr    <= '0;
            wb_cti    <= 3'b000;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            rsp_last  <= 1'b0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            // Response strobes are single-cycle pulses.
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_last  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        wb_adr   <= WbAdrW'((cmd_address & LineMask) >> ByteOffBits);
                        beat_cnt <= '0;
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        wb_cti   <= CtiIncr;
                        state_q  <= StBurst;
`ifdef ICACHE_REFILL_TIMEOUT_EN
                        wd_q     <= '0;
`endif
                    end
                end
                StBurst: begin
                    if (wb_ack || wb_err) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= wb_dat_r;
                        rsp_error <= wb_err;
                        rsp_last  <= (beat_cnt == LastBeat);
                        wb_adr    <= wb_adr + WbAdrW'(1);
                        beat_cnt  <= beat_cnt + CntW'(1);
`ifdef ICACHE_REFILL_TIMEOUT_EN
                        wd_q      <= '0;
`endif
                        if (beat_cnt == LastBeat) begin
                            wb_cyc  <= 1'b0;
                            wb_stb  <= 1'b0;
                            wb_cti  <= 3'b000;
                            state_q <= StIdle;
                        end else begin
                            wb_cti <= (beat_cnt + CntW'(1) == LastBeat) ? CtiEnd : CtiIncr;
                        end
                    end
`ifdef ICACHE_REFILL_TIMEOUT_EN
                    else if (wd_q == TimeoutLast) begin
                        // Slave went silent: release the bus, finish the line with errors.
                        wb_cyc  <= 1'b0;
                        wb_stb  <= 1'b0;
                        wb_cti  <= 3'b000;
                        state_q <= StAbort;
                    end else begin
                        wd_q <= wd_q + TimeoutW'(1);
                    end
`endif
                end
`ifdef ICACHE_REFILL_TIMEOUT_EN
                StAbort: begin
                    // Late acks are ignored here; every remaining beat reports an error.
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_error <= 1'b1;
                    rsp_last  <= (beat_cnt == LastBeat);
                    beat_cnt  <= beat_cnt + CntW'(1);
                    if (beat_cnt == LastBeat) begin
                        state_q <= StIdle;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_wb.sv
// Self-checking bench for icache_refill_wb: the bench plays the Wishbone slave with
// random wait states, data and errors, and predicts every bus/response cycle from the
// line-fill rules (line base address, beat order, one-cycle response latency).
module tb_icache_refill_wb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid, cmd_ready;
    logic [AW-1:0]     cmd_address;
    logic              rsp_valid, rsp_error, rsp_last;
    logic [DW-1:0]     rsp_data;
    logic              wb_cyc, wb_stb;
    logic [AW-3:0]     wb_adr;
    logic [DW/8-1:0]   wb_sel;
    logic [2:0]        wb_cti;
    logic [1:0]        wb_bte;
    logic [DW-1:0]     wb_dat_r;
    logic              wb_ack, wb_err;

    int n_cmp = 0;
    int n_err = 0;

    // Pending response predicted for the next sample point.
    logic          exp_pend;
    logic [DW-1:0] exp_data;
    logic          exp_err, exp_last;

    always #5 clk = ~clk;

    icache_refill_wb #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .LINE_WORDS     (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_address (cmd_address),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .rsp_last    (rsp_last),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_adr      (wb_adr),
        .wb_sel      (wb_sel),
        .wb_cti      (wb_cti),
        .wb_bte      (wb_bte),
        .wb_dat_r    (wb_dat_r),
        .wb_ack      (wb_ack),
        .wb_err      (wb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input logic ecyc, input logic [63:0] eadr,
                               input logic [2:0] ecti, input logic erdy);
        chk("wb_cyc", wb_cyc, ecyc);
        chk("wb_stb", wb_stb, ecyc);
        if (ecyc) begin
            chk("wb_adr", wb_adr, eadr);
            chk("wb_cti", wb_cti, ecti);
        end
        chk("cmd_ready", cmd_ready, erdy);
        chk("rsp_valid", rsp_valid, exp_pend);
        if (exp_pend) begin
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_error", rsp_error, exp_err);
            chk("rsp_last", rsp_last, exp_last);
        end
        exp_pend = 1'b0;
    endtask

    // One line fill. slow_mask bit k forces 3 wait states on beat k; err_beat gets
    // ack+err together; rnd_err picks ack / err / both per beat; rst_beat resets the
    // DUT on the cycle after that beat's ack.
    task automatic do_fill(input logic [AW-1:0] addr, input int max_wait, input int slow_mask,
                           input int err_beat, input bit rnd_err, input bit hold_valid,
                           input int rst_beat);
        longint base;
        int     w;
        int     mode;
        base = (longint'(addr) / (LW * DW / 8)) * LW;
        cmd_valid   = 1'b1;
        cmd_address = addr;
        step();
        cmd_valid   = hold_valid;
        cmd_address = $urandom;   // must be ignored while the burst runs
        for (int k = 0; k < LW; k++) begin
            w = slow_mask[k] ? 3 : ((max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0);
            for (int j = 0; j <= w; j++) begin
                check_cycle(1'b1, base + k, (k == LW - 1) ? 3'b111 : 3'b010, 1'b0);
                wb_dat_r = $urandom;
                if (j == w) begin
                    mode     = rnd_err ? int'($urandom_range(2, 0)) : ((k == err_beat) ? 2 : 0);
                    wb_ack   = (mode != 1);
                    wb_err   = (mode != 0);
                    exp_pend = 1'b1;
                    exp_data = wb_dat_r;
                    exp_err  = (mode != 0);
                    exp_last = (k == LW - 1);
                end else begin
                    wb_ack = 1'b0;
                    wb_err = 1'b0;
                end
                step();
            end
            wb_ack = 1'b0;
            wb_err = 1'b0;
            if (k == rst_beat) begin
                check_cycle(1'b1, base + k + 1, (k + 1 == LW - 1) ? 3'b111 : 3'b010, 1'b0);
                reset = 1'b1;
                step();
                check_cycle(1'b0, 0, 3'b000, 1'b0);
                chk("wb_adr_after_reset", wb_adr, 0);
                reset = 1'b0;
                step();
                check_cycle(1'b0, 0, 3'b000, 1'b1);
                return;
            end
        end
        check_cycle(1'b0, 0, 3'b000, 1'b1);
    endtask

    initial begin
        bit hold;
        bit prev_hold;
        cmd_valid   = 1'b0;
        cmd_address = '0;
        wb_dat_r    = '0;
        wb_ack      = 1'b0;
        wb_err      = 1'b0;
        exp_pend    = 1'b0;
        exp_data    = '0;
        exp_err     = 1'b0;
        exp_last    = 1'b0;

        // Reset state
        reset = 1'b1;
        step();
        step();
        check_cycle(1'b0, 0, 3'b000, 1'b0);
        chk("reset_wb_adr", wb_adr, 0);
        chk("reset_wb_cti", wb_cti, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_error", rsp_error, 0);
        chk("reset_rsp_last", rsp_last, 0);
        chk("wb_sel", wb_sel, 4'hf);
        chk("wb_bte", wb_bte, 2'b00);
        reset = 1'b0;
        step();
        check_cycle(1'b0, 0, 3'b000, 1'b1);

        // Normal fill, ack every cycle; word base 0x1000_0000
        do_fill(32'h4000_0014, 0, 0, -1, 1'b0, 1'b0, -1);
        step();
        check_cycle(1'b0, 0, 3'b000, 1'b1);
        // Wait states on beats 0 and 5
        do_fill(32'h8000_1234, 0, 'b10_0001, -1, 1'b0, 1'b0, -1);
        // Error together with ack on beat 3
        do_fill(32'h0000_0ffc, 0, 0, 3, 1'b0, 1'b0, -1);
        // Reset on the cycle after beat 2's ack, then a clean fill
        do_fill(32'h1234_5678, 0, 0, -1, 1'b0, 1'b0, 2);
        do_fill(32'h2000_0040, 1, 0, -1, 1'b0, 1'b0, -1);
        // Back-to-back with cmd_valid held high
        do_fill(32'hdead_bee0, 0, 0, -1, 1'b0, 1'b1, -1);
        do_fill(32'hcafe_f00d, 0, 0, -1, 1'b0, 1'b0, -1);

        // Random fills: wait states, data, ack/err mix, idle gaps with stray acks
        prev_hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!prev_hold) begin
                repeat ($urandom_range(2, 0)) begin
                    wb_ack      = $urandom_range(1, 0);
                    cmd_address = $urandom;
                    step();
                    check_cycle(1'b0, 0, 3'b000, 1'b1);
                end
                wb_ack = 1'b0;
            end
            hold = (i < 19) ? 1'($urandom_range(1, 0)) : 1'b0;
            do_fill($urandom, 3, 0, -1, 1'b1, hold, -1);
            prev_hold = hold;
        end

`ifdef ICACHE_REFILL_TIMEOUT_EN
        // Watchdog: beats 0 and 1 acked, then the slave goes silent
        cmd_valid   = 1'b1;
        cmd_address = 32'h0000_0100;
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_cycle(1'b1, 64'h40 + k, 3'b010, 1'b0);
            wb_dat_r = $urandom;
            wb_ack   = 1'b1;
            exp_pend = 1'b1;
            exp_data = wb_dat_r;
            exp_err  = 1'b0;
            exp_last = 1'b0;
            step();
            wb_ack = 1'b0;
        end
        for (int j = 0; j < TO; j++) begin
            check_cycle(1'b1, 64'h42, 3'b010, 1'b0);
            step();
        end
        check_cycle(1'b0, 0, 3'b000, 1'b0);
        wb_ack = 1'b1;   // late ack must be ignored
        for (int k = 2; k < LW; k++) begin
            exp_pend = 1'b1;
            exp_data = '0;
            exp_err  = 1'b1;
            exp_last = (k == LW - 1);
            step();
            check_cycle(1'b0, 0, 3'b000, (k == LW - 1));
        end
        step();
        wb_ack = 1'b0;
        check_cycle(1'b0, 0, 3'b000, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
